// File: rtl/ssd_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit seven-segment display with
// inter-digit blanking and per-frame input snapshot. Optional dimming: SSD_DIM_EN.
module ssd_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic [3:0] digit0_i,
    input  logic       digit1_en_i,
    input  logic [3:0] digit1_i,
    input  logic       digit2_en_i,
    input  logic [3:0] digit2_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit3_i,
`ifdef SSD_DIM_EN
    input  logic       dim_i,
`endif
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o,
    output logic       frame_start_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);
`ifdef SSD_DIM_EN
    localparam logic [CNT_W-1:0] DIM_START   = CNT_W'((REFRESH_DIV + BLANK_CYCLES) / 2);
`endif

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [3:0]       en_reg;
    logic [3:0][3:0]  val_reg;
    logic [3:0]       en_in;
    logic [3:0][3:0]  val_in;
    logic [3:0]       anode_reg, anode_next, anode_sel;
    logic [6:0]       seg_reg, seg_next;
    logic             frame_start_reg;
    logic             capture;
    logic [CNT_W-1:0] active_start;
`ifdef SSD_DIM_EN
    logic             dim_reg;
`endif

    assign en_in  = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
    assign val_in = {digit3_i, digit2_i, digit1_i, digit0_i};

    // One-cold anode pattern for the digit currently being scanned.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign anode_sel[gi] = (idx_reg != 2'(gi));
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SSD_DIM_EN
    assign active_start = dim_reg ? DIM_START : BLANK_START;
`else
    assign active_start = BLANK_START;
`endif

    assign capture = (cnt_reg == '0) && (idx_reg == 2'd0);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            idx_next = idx_reg + 2'd1;
        end
    end

    // The leading part of every slot stays dark, so anodes never hand over directly.
    always_comb begin
        anode_next = 4'hF;
        seg_next   = 7'h7F;
        if ((cnt_reg >= active_start) && en_reg[idx_reg]) begin
            anode_next = anode_sel;
            seg_next   = seg_decode(val_reg[idx_reg]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg         <= '0;
            idx_reg         <= 2'd0;
            en_reg          <= 4'h0;
            val_reg         <= '0;
            anode_reg       <= 4'hF;
            seg_reg         <= 7'h7F;
            frame_start_reg <= 1'b0;
`ifdef SSD_DIM_EN
            dim_reg         <= 1'b0;
`endif
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            anode_reg       <= anode_next;
            seg_reg         <= seg_next;
            frame_start_reg <= capture;
            if (capture) begin
                en_reg  <= en_in;
                val_reg <= val_in;
`ifdef SSD_DIM_EN
                dim_reg <= dim_i;
`endif
            end
        end
    end

    assign anode_o       = anode_reg;
    assign segments_o    = seg_reg;
    assign dp_o          = 1'b1;
    assign frame_start_o = frame_start_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a frame-level reference model predicts each
// cycle's display outputs; a negedge monitor compares them against the DUT.
module tb_ssd_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       tb_en [4];
    logic [3:0] tb_val [4];
    logic       tb_dim;
    logic [3:0] anode_o;
    logic [6:0] segments_o;
    logic       dp_o;
    logic       frame_start_o;

    logic [6:0] dec_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    exp_t       q [$];
    int         total = 0;
    int         bad   = 0;
    int         s     = 0;
    int         frame_no = 0;
    logic       snap_en [4];
    logic [3:0] snap_val [4];
    logic       snap_dim;

    always #5 clk = ~clk;

    ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .digit0_en_i  (tb_en[0]),
        .digit0_i     (tb_val[0]),
        .digit1_en_i  (tb_en[1]),
        .digit1_i     (tb_val[1]),
        .digit2_en_i  (tb_en[2]),
        .digit2_i     (tb_val[2]),
        .digit3_en_i  (tb_en[3]),
        .digit3_i     (tb_val[3]),
`ifdef SSD_DIM_EN
        .dim_i        (tb_dim),
`endif
        .anode_o      (anode_o),
        .segments_o   (segments_o),
        .dp_o         (dp_o),
        .frame_start_o(frame_start_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h required %h", name, $time, act, req);
        end
    endtask

    // Reference: s = cycles elapsed since reset release; the slot position and digit
    // follow from s by division, and a snapshot is taken at every multiple of FRAME.
    task automatic step();
        int         cnt, idx, start;
        logic [3:0] one;
        exp_t       e;
        @(posedge clk);
        cnt   = s % RD;
        idx   = (s / RD) % 4;
        start = snap_dim ? (RD + BC) / 2 : BC;
        e.fs  = ((s % FRAME) == 0);
        if (cnt >= start && snap_en[idx]) begin
            one     = 4'b0001;
            e.anode = ~(one << idx);
            e.seg   = dec_tbl[snap_val[idx]];
        end else begin
            e.anode = 4'hF;
            e.seg   = 7'h7F;
        end
        if (e.fs) begin
            for (int i = 0; i < 4; i++) begin
                snap_en[i]  = tb_en[i];
                snap_val[i] = tb_val[i];
            end
`ifdef SSD_DIM_EN
            snap_dim = tb_dim;
`endif
            $display("frame %0d: en=%b%b%b%b val=%h%h%h%h dim=%b", frame_no,
                     snap_en[3], snap_en[2], snap_en[1], snap_en[0],
                     snap_val[3], snap_val[2], snap_val[1], snap_val[0], snap_dim);
            frame_no++;
        end
        q.push_back(e);
        s++;
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align_frame();
        while ((s % FRAME) != 0) step();
    endtask

    task automatic model_reset();
        s = 0;
        for (int i = 0; i < 4; i++) begin
            snap_en[i]  = 1'b0;
            snap_val[i] = 4'h0;
        end
        snap_dim = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("anode", 32'(anode_o), 32'(e.anode));
                chk("segments", 32'(segments_o), 32'(e.seg));
                chk("frame_start", 32'(frame_start_o), 32'(e.fs));
                chk("dp", 32'(dp_o), 32'd1);
            end
        end
    end

    initial begin
        logic found;
        model_reset();
        rst_ni = 1'b0;
        tb_dim = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_en[i]  = 1'b1;
            tb_val[i] = 4'(i + 1);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset_anode", 32'(anode_o), 32'hF);
        chk("reset_segments", 32'(segments_o), 32'h7F);
        chk("reset_dp", 32'(dp_o), 32'd1);
        chk("reset_frame_start", 32'(frame_start_o), 32'd0);

        // Basic scan of 1,2,3,4
        @(negedge clk);
        #1;
        rst_ni = 1'b1;
        run(2 * FRAME);

        // Digits 1 and 3 disabled
        tb_en[1] = 1'b0;
        tb_en[3] = 1'b0;
        run(2 * FRAME);
        tb_en[1] = 1'b1;
        tb_en[3] = 1'b1;

        // digit0 changes 5 -> A during slot 2
        align_frame();
        tb_val[0] = 4'h5;
        run(2 * RD + 3);
        tb_val[0] = 4'hA;
        align_frame();
        run(2 * FRAME);

        // Randomised inputs changing at arbitrary cycles
        for (int i = 0; i < 12 * FRAME; i++) begin
            if ($urandom_range(7) == 0) begin
                int d;
                d = $urandom_range(3);
                tb_en[d]  = 1'($urandom);
                tb_val[d] = 4'($urandom);
            end
`ifdef SSD_DIM_EN
            if ($urandom_range(15) == 0) tb_dim = 1'($urandom);
`endif
            step();
        end

`ifdef SSD_DIM_EN
        align_frame();
        tb_dim = 1'b1;
        for (int i = 0; i < 4; i++) tb_en[i] = 1'b1;
        run(2 * FRAME);
        tb_dim = 1'b0;
`endif

        // Decode sweep on digit 2
        for (int v = 0; v < 16; v++) begin
            align_frame();
            tb_en[2]  = 1'b1;
            tb_val[2] = 4'(v);
            run(FRAME);
        end

        // Asynchronous reset while digit 2 is lit
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            step();
            if (anode_o == 4'b1011) found = 1'b1;
        end
        chk("reach_digit2_lit", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_reset_anode", 32'(anode_o), 32'hF);
        chk("async_reset_segments", 32'(segments_o), 32'h7F);
        chk("async_reset_frame_start", 32'(frame_start_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tb_en[i]  = 1'($urandom);
            tb_val[i] = 4'($urandom);
        end
        tb_en[0] = 1'b1;
        rst_ni = 1'b1;
        run(2 * FRAME);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
